instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the multicycle 16-bit processor.
- Owns the program counter and instruction register.
- Performs a handshaked word read from instruction memory when the control FSM requests a fetch.
- Presents the latched instruction and a link value (fetched address + 1) to the control FSM and datapath; accepts PC redirects for branch/jump/JAL.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT, 16, max cycles in REQ before abort; 0 disables timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_start  in  1  pulse from control FSM; begin fetch at current PC
- pc_load  in  1  redirect PC to pc_target
- pc_target  in  16  branch/jump target address
- mem_req  out  1  memory read request, held until mem_ack or timeout
- mem_addr  out  16  read address; valid while mem_req=1
- mem_rdata  in  16  memory read data; sampled when mem_ack=1
- mem_ack  in  1  memory read complete
- instruction  out  16  instruction register contents
- instr_valid  out  1  one-cycle pulse: instruction newly latched
- pc  out  16  address of next fetch
- pc_link  out  16  address of last fetched instruction + 1 (JAL link)
- busy  out  1  high in REQ
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: reset is reset, asynchronous, active-high; clock is clk.
- Reset values: pc=RESET_PC, instruction=0, pc_link=0, state=IDLE; mem_req, instr_valid, busy, bus_err all 0; pending-load flag cleared; timeout counter 0.
- Reset asserted mid-REQ drops mem_req immediately and discards the in-flight read.
- States: IDLE, REQ, VALID.
- IDLE:
  - pc_load=1 -> pc<=pc_target.
  - fetch_start=1 -> REQ. If pc_load and fetch_start occur in the same cycle, the fetch uses pc_target.
- REQ:
  - mem_req=1, busy=1, mem_addr=pc (registered; stable for the whole request).
  - fetch_start is ignored.
  - pc_load in REQ is not lost: latch pending_target and set the pending flag. A later pc_load in the same REQ overwrites pending_target.
  - On mem_ack=1: instruction<=mem_rdata; pc_link<=pc+1 (16-bit wrap, FFFF->0000); pc<= (pending ? pending_target : pc+1); clear pending; -> VALID.
  - mem_ack in the first REQ cycle is legal, giving minimum latency: fetch_start cycle N, mem_req cycle N+1, ack N+1, instr_valid N+2.
  - Timeout counter counts REQ cycles without ack. When it reaches TIMEOUT (TIMEOUT>0) with no ack that cycle: drop mem_req, pulse bus_err for 1 cycle, leave instruction/pc_link unchanged, apply a pending load to pc if present (else pc unchanged), -> IDLE.
  - Ack on the same cycle the counter reaches TIMEOUT wins; no error is raised.
- VALID:
  - instr_valid=1 for exactly this cycle.
  - pc_load is honoured as in IDLE.
  - fetch_start=1 -> REQ directly (back-to-back fetch, no IDLE bubble); else -> IDLE.
- mem_ack while not in REQ is ignored.
- instruction holds its value until the next successful fetch, so the control FSM may decode it over multiple cycles.
- pc, pc_link and instruction are registered outputs. instr_valid, busy and mem_req are decoded from state.

Test Plan:
- Reset with RESET_PC=16'h0010; fetch_start; memory acks 2 cycles later with 16'h5123 -> mem_addr=0010 while mem_req=1; instruction=5123, instr_valid pulses once, pc=0011, pc_link=0011.
- Zero-wait ack (mem_ack same cycle mem_req rises), 3 back-to-back fetches issued in the VALID cycle -> addresses 0010, 0011, 0012; each fetch takes exactly 2 cycles from fetch_start to instr_valid.
- IDLE pc_load=1, pc_target=16'h0400 together with fetch_start -> mem_addr=0400; after ack, pc=0401.
- pc_load pc_target=16'h0200 while in REQ at pc=0030, ack with 16'hC0FF -> instruction=C0FF, pc_link=0031, pc=0200.
- pc=16'hFFFF fetch -> pc wraps to 0000, pc_link=0000.
- TIMEOUT=16, memory never acks -> mem_req high exactly 16 cycles then low, bus_err pulses once, instruction and pc unchanged, state IDLE. Repeat with ack on the 16th cycle -> no bus_err, instr_valid pulses.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and instruction register, issues handshaked word reads.
// Latency: fetch_start -> instr_valid in 2 cycles minimum; mem_req held until ack or TIMEOUT abort.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_link,
    output logic        busy,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

    localparam logic [15:0] TO_LAST = (TIMEOUT != 0) ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] link_q, link_d;
    logic [15:0] pend_tgt_q, pend_tgt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        pend_q, pend_d;
    logic        bus_err_q, bus_err_d;

    logic        timeout_hit;
    logic [15:0] pc_inc;
    logic        load_any;
    logic [15:0] load_tgt;

    assign pc_inc   = pc_q + 16'd1;
    // A pc_load arriving on the completing cycle takes precedence over an older pending one.
    assign load_any = pc_load | pend_q;
    assign load_tgt = pc_load ? pc_target : pend_tgt_q;

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign timeout_hit = (state_q == S_REQ) && !mem_ack && (tcnt_q == TO_LAST);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fetch_start) state_d = S_REQ;
            S_REQ: begin
                if (mem_ack)          state_d = S_VALID;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_VALID: state_d = fetch_start ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = (state_q == S_REQ);
        busy        = (state_q == S_REQ);
        instr_valid = (state_q == S_VALID);
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        link_d     = link_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        tcnt_d     = 16'd0;
        bus_err_d  = 1'b0;
        case (state_q)
            S_REQ: begin
                tcnt_d = tcnt_q + 16'd1;
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    link_d  = pc_inc;
                    pc_d    = load_any ? load_tgt : pc_inc;
                    pend_d  = 1'b0;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    if (load_any) pc_d = load_tgt;
                    pend_d = 1'b0;
                end else if (pc_load) begin
                    // PC must stay stable as the request address, so park the redirect.
                    pend_d     = 1'b1;
                    pend_tgt_d = pc_target;
                end
            end
            default: begin
                if (pc_load) pc_d = pc_target;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 16'd0;
            link_q     <= 16'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 16'd0;
            tcnt_q     <= 16'd0;
            bus_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            link_q     <= link_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            tcnt_q     <= tcnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign pc_link     = link_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC=0010 and TIMEOUT=16.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_link;
    logic        busy;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int n;

    instr_fetch_unit #(.RESET_PC(16'h0010), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_link     (pc_link),
        .busy        (busy),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_target = 16'h0;
        mem_rdata = 16'h0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 16'h0010);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_link", pc_link, 16'h0000);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_err", {15'd0, bus_err}, 16'd0);
        reset = 1'b0;
        tick();

        // Basic fetch, ack on the second REQ cycle
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        chk("t1_req", {15'd0, mem_req}, 16'd1);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        chk("t1_addr", mem_addr, 16'h0010);
        tick();
        chk("t1_req2", {15'd0, mem_req}, 16'd1);
        chk("t1_addr2", mem_addr, 16'h0010);
        mem_ack = 1'b1; mem_rdata = 16'h5123; tick(); mem_ack = 1'b0;
        chk("t1_valid", {15'd0, instr_valid}, 16'd1);
        chk("t1_reqoff", {15'd0, mem_req}, 16'd0);
        chk("t1_instr", instruction, 16'h5123);
        chk("t1_pc", pc, 16'h0011);
        chk("t1_link", pc_link, 16'h0011);
        tick();
        chk("t1_valid_once", {15'd0, instr_valid}, 16'd0);

        // Back-to-back zero-wait fetches from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_start = 1'b1; tick(); fetch_start = 1'b0;
            chk("t2_req", {15'd0, mem_req}, 16'd1);
            chk("t2_addr", mem_addr, 16'h0010 + 16'(i));
            mem_ack = 1'b1; mem_rdata = 16'hA000 + 16'(i); tick(); mem_ack = 1'b0;
            chk("t2_valid", {15'd0, instr_valid}, 16'd1);
            chk("t2_instr", instruction, 16'hA000 + 16'(i));
            chk("t2_pc", pc, 16'h0011 + 16'(i));
        end
        tick();
        chk("t2_idle", {15'd0, instr_valid}, 16'd0);

        // Ack outside REQ is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD; tick(); mem_ack = 1'b0;
        chk("ign_instr", instruction, 16'hA002);
        chk("ign_valid", {15'd0, instr_valid}, 16'd0);
        chk("ign_req", {15'd0, mem_req}, 16'd0);

        // pc_load together with fetch_start in IDLE
        pc_load = 1'b1; pc_target = 16'h0400; fetch_start = 1'b1; tick();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("t3_addr", mem_addr, 16'h0400);
        mem_ack = 1'b1; mem_rdata = 16'h1234; tick(); mem_ack = 1'b0;
        chk("t3_pc", pc, 16'h0401);
        chk("t3_link", pc_link, 16'h0401);
        tick();

        // pc_load during REQ is deferred until completion
        pc_load = 1'b1; pc_target = 16'h0030; tick(); pc_load = 1'b0;
        chk("t4_pcload", pc, 16'h0030);
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        chk("t4_addr", mem_addr, 16'h0030);
        pc_load = 1'b1; pc_target = 16'h0200; tick(); pc_load = 1'b0;
        chk("t4_addr_stable", mem_addr, 16'h0030);
        chk("t4_req_held", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'hC0FF; tick(); mem_ack = 1'b0;
        chk("t4_instr", instruction, 16'hC0FF);
        chk("t4_link", pc_link, 16'h0031);
        chk("t4_pc", pc, 16'h0200);
        tick();

        // PC wrap at FFFF
        pc_load = 1'b1; pc_target = 16'hFFFF; fetch_start = 1'b1; tick();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("t5_addr", mem_addr, 16'hFFFF);
        mem_ack = 1'b1; mem_rdata = 16'h7777; tick(); mem_ack = 1'b0;
        chk("t5_pc", pc, 16'h0000);
        chk("t5_link", pc_link, 16'h0000);
        tick();

        // Timeout: memory never acks
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && mem_req; k++) begin
            n++;
            chk("t6_no_early_err", {15'd0, bus_err}, 16'd0);
            tick();
        end
        chk("t6_req_cycles", 16'(n), 16'd16);
        chk("t6_err", {15'd0, bus_err}, 16'd1);
        chk("t6_busy", {15'd0, busy}, 16'd0);
        chk("t6_valid", {15'd0, instr_valid}, 16'd0);
        chk("t6_instr", instruction, 16'h7777);
        chk("t6_pc", pc, 16'h0000);
        tick();
        chk("t6_err_once", {15'd0, bus_err}, 16'd0);
        chk("t6_idle", {15'd0, mem_req}, 16'd0);

        // Ack on the 16th REQ cycle wins over timeout
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("t7_req16", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'h9ABC; tick(); mem_ack = 1'b0;
        chk("t7_valid", {15'd0, instr_valid}, 16'd1);
        chk("t7_err", {15'd0, bus_err}, 16'd0);
        chk("t7_instr", instruction, 16'h9ABC);
        chk("t7_pc", pc, 16'h0001);
        tick();
        chk("t7_err_after", {15'd0, bus_err}, 16'd0);

        // Asynchronous reset mid-REQ drops the request at once
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        chk("t8_req", {15'd0, mem_req}, 16'd1);
        reset = 1'b1; #1;
        chk("t8_req_drop", {15'd0, mem_req}, 16'd0);
        chk("t8_pc", pc, 16'h0010);
        chk("t8_instr", instruction, 16'h0000);
        tick(); reset = 1'b0; tick();
        chk("t8_idle", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
